axis_rr_arbiter: RTL and testbench

//  Packet-aware round-robin arbiter that shares one AXI-Stream sink between NUM_SRC AXI-Stream sources.

---
 rtl/axis_rr_arbiter.sv | 96 +++++++++
 tb/tb_axis_rr_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin arbiter: one registered arbitration cycle in IDLE, then zero-latency muxing of the granted source.
// Backpressure passes straight through to the granted source only; no data is buffered.

module axis_rr_arbiter #(
   parameter int  NUM_SRC = 4,
   parameter int  WIDTH   = 32,
   localparam int ID_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
   localparam int KW      = WIDTH / 8
) (
   input  logic                       aclk,
   input  logic                       areset,
   input  logic [NUM_SRC-1:0]         s_axis_tvalid,
   output logic [NUM_SRC-1:0]         s_axis_tready,
   input  logic [NUM_SRC*WIDTH-1:0]   s_axis_tdata,
   input  logic [NUM_SRC*KW-1:0]      s_axis_tkeep,
   input  logic [NUM_SRC-1:0]         s_axis_tlast,
   output logic                       m_axis_tvalid,
   input  logic                       m_axis_tready,
   output logic [WIDTH-1:0]           m_axis_tdata,
   output logic [KW-1:0]              m_axis_tkeep,
   output logic                       m_axis_tlast,
   output logic [ID_W-1:0]            m_axis_tid,
   output logic [NUM_SRC-1:0]         grant,
   output logic                       busy
);

   typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

   state_t          state, state_nxt;
   logic [ID_W-1:0] sel;
   logic [ID_W-1:0] last_grant;
   logic [ID_W-1:0] winner;
   logic [ID_W:0]   scan;
   logic            beat_done;

   // Scan downwards so the nearest requester after last_grant overwrites any farther one.
   always_comb begin
      winner = last_grant;
      scan   = '0;
      for (int k = NUM_SRC; k >= 1; k--) begin
         scan = {1'b0, last_grant} + (ID_W+1)'(k);
         if (scan >= (ID_W+1)'(NUM_SRC))
            scan = scan - (ID_W+1)'(NUM_SRC);
         if (s_axis_tvalid[scan[ID_W-1:0]])
            winner = scan[ID_W-1:0];
      end
   end

   assign beat_done = m_axis_tvalid & m_axis_tready & m_axis_tlast;

   always_ff @(posedge aclk) begin
      if (areset) begin
         state      <= IDLE;
         sel        <= '0;
         last_grant <= ID_W'(NUM_SRC - 1);
      end else begin
         state <= state_nxt;
         if (state == IDLE && |s_axis_tvalid)
            sel <= winner;
         if (beat_done)
            last_grant <= sel;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (|s_axis_tvalid) state_nxt = XFER;
         XFER:    if (beat_done)      state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Grant is locked for the whole packet; a valid bubble from the owner just shows as m_axis_tvalid = 0.
   always_comb begin
      s_axis_tready = '0;
      m_axis_tvalid = 1'b0;
      m_axis_tdata  = '0;
      m_axis_tkeep  = '0;
      m_axis_tlast  = 1'b0;
      grant         = '0;
      busy          = 1'b0;
      if (state == XFER) begin
         busy               = 1'b1;
         grant[sel]         = 1'b1;
         m_axis_tvalid      = s_axis_tvalid[sel];
         m_axis_tdata       = s_axis_tdata[sel*WIDTH +: WIDTH];
         m_axis_tkeep       = s_axis_tkeep[sel*KW +: KW];
         m_axis_tlast       = s_axis_tlast[sel];
         s_axis_tready[sel] = m_axis_tready;
      end
   end

   assign m_axis_tid = sel;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Self-checking bench for axis_rr_arbiter: directed arbitration/stall/reset cases plus a random scoreboard run.
// Per-source expected beats are queued when loaded into the source models and popped as the sink accepts them.

module tb_axis_rr_arbiter;
   localparam int N   = 4;
   localparam int W   = 32;
   localparam int KW  = W / 8;
   localparam int IDW = 2;

   typedef struct packed {
      logic [W-1:0]  d;
      logic [KW-1:0] k;
      logic          l;
   } beat_t;

   logic             aclk = 1'b0;
   logic             areset;
   logic [N-1:0]     s_axis_tvalid;
   logic [N-1:0]     s_axis_tready;
   logic [N*W-1:0]   s_axis_tdata;
   logic [N*KW-1:0]  s_axis_tkeep;
   logic [N-1:0]     s_axis_tlast;
   logic             m_axis_tvalid;
   logic             m_axis_tready;
   logic [W-1:0]     m_axis_tdata;
   logic [KW-1:0]    m_axis_tkeep;
   logic             m_axis_tlast;
   logic [IDW-1:0]   m_axis_tid;
   logic [N-1:0]     grant;
   logic             busy;

   axis_rr_arbiter #(.NUM_SRC(N), .WIDTH(W)) dut (
      .aclk(aclk), .areset(areset),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
      .m_axis_tid(m_axis_tid), .grant(grant), .busy(busy)
   );

   always #5 aclk = ~aclk;

   beat_t      src_q[N][$];
   beat_t      exp_q[N][$];
   int         log_tid[$];
   int         log_cyc[$];
   int         n_chk = 0;
   int         n_err = 0;
   int         cyc = 0;
   int         beats_out = 0;
   int         acc_cnt[N];
   int         seq[N];
   logic [N-1:0] src_acc = '0;
   logic [N-1:0] drop = '0;
   int         vld_pct = 100;
   int         rdy_pct = 100;
   logic       m_rdy = 1'b1;
   logic       rst_req = 1'b1;
   logic       pkt_open = 1'b0;
   int         pkt_src = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive();
      beat_t b;
      areset = rst_req;
      for (int i = 0; i < N; i++) begin
         if (src_acc[i] && src_q[i].size() > 0)
            void'(src_q[i].pop_front());
         if (src_q[i].size() > 0) begin
            b = src_q[i][0];
            s_axis_tdata[i*W +: W]   = b.d;
            s_axis_tkeep[i*KW +: KW] = b.k;
            s_axis_tlast[i]          = b.l;
            s_axis_tvalid[i]         = !drop[i] && (int'($urandom_range(99)) < vld_pct);
         end else begin
            s_axis_tdata[i*W +: W]   = '0;
            s_axis_tkeep[i*KW +: KW] = '0;
            s_axis_tlast[i]          = 1'b0;
            s_axis_tvalid[i]         = 1'b0;
         end
      end
      m_axis_tready = m_rdy && (int'($urandom_range(99)) < rdy_pct);
   endtask

   task automatic monitor();
      int t;
      beat_t e;
      cyc++;
      for (int i = 0; i < N; i++) begin
         src_acc[i] = s_axis_tvalid[i] & s_axis_tready[i];
         if (src_acc[i]) acc_cnt[i]++;
      end
      if (m_axis_tvalid && m_axis_tready) begin
         t = int'(m_axis_tid);
         log_tid.push_back(t);
         log_cyc.push_back(cyc);
         beats_out++;
         chk("sb_has_exp", exp_q[t].size() > 0, 1);
         if (exp_q[t].size() > 0) begin
            e = exp_q[t].pop_front();
            chk("sb_data", m_axis_tdata, e.d);
            chk("sb_keep", m_axis_tkeep, e.k);
            chk("sb_last", m_axis_tlast, e.l);
         end
         if (pkt_open) chk("sb_contig", t, pkt_src);
         pkt_open = !m_axis_tlast;
         pkt_src  = t;
      end
   endtask

   task automatic step();
      @(posedge aclk);
      #1;
      drive();
      @(negedge aclk);
      monitor();
   endtask

   task automatic flush_all();
      for (int i = 0; i < N; i++) begin
         src_q[i].delete();
         exp_q[i].delete();
      end
      src_acc  = '0;
      drop     = '0;
      pkt_open = 1'b0;
   endtask

   task automatic do_reset();
      rst_req = 1'b1;
      step();
      step();
      flush_all();
      rst_req = 1'b0;
   endtask

   task automatic load_pkt(input int s, input int len);
      beat_t b;
      for (int i = 0; i < len; i++) begin
         b.d = {s[3:0], seq[s][27:0]};
         b.k = KW'($urandom_range(15));
         b.l = (i == len - 1);
         seq[s]++;
         src_q[s].push_back(b);
         exp_q[s].push_back(b);
      end
   endtask

   function automatic bit src_pending();
      for (int i = 0; i < N; i++)
         if (src_q[i].size() > 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic drain(input int max, input string tag);
      int k = 0;
      while ((src_pending() || busy) && k < max) begin
         step();
         k++;
      end
      chk(tag, k < max, 1);
   endtask

   task automatic wait_acc(input int s, input int n, input int max, input string tag);
      int k = 0;
      while (acc_cnt[s] < n && k < max) begin
         step();
         k++;
      end
      chk(tag, k < max, 1);
   endtask

   initial begin
      int base;
      int target;
      int k;
      logic [W-1:0] stall_d;

      areset = 1'b1;
      s_axis_tvalid = '0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = '0;
      m_axis_tready = 1'b0;
      for (int i = 0; i < N; i++) begin
         acc_cnt[i] = 0;
         seq[i] = 0;
      end

      // Reset values, then src0/src2 two-beat packets
      do_reset();
      chk("rst_grant", grant, 0);
      chk("rst_busy", busy, 0);
      chk("rst_mvalid", m_axis_tvalid, 0);
      chk("rst_tid", m_axis_tid, 0);
      chk("rst_sready", s_axis_tready, 0);
      chk("rst_mdata", {m_axis_tdata, m_axis_tkeep, m_axis_tlast}, 0);
      load_pkt(0, 2);
      load_pkt(2, 2);
      log_tid.delete(); log_cyc.delete();
      drain(50, "t1_timeout");
      chk("t1_nbeats", log_tid.size(), 4);
      if (log_tid.size() == 4) begin
         chk("t1_tid0", log_tid[0], 0);
         chk("t1_tid1", log_tid[1], 0);
         chk("t1_tid2", log_tid[2], 2);
         chk("t1_tid3", log_tid[3], 2);
         chk("t1_gap_in_pkt", log_cyc[1] - log_cyc[0], 1);
         chk("t1_gap_idle", log_cyc[2] - log_cyc[1], 2);
         chk("t1_gap_in_pkt2", log_cyc[3] - log_cyc[2], 1);
      end

      // All four sources, single-beat packets: strict rotation, one beat every 2nd cycle
      do_reset();
      for (int r = 0; r < 3; r++)
         for (int s = 0; s < N; s++) load_pkt(s, 1);
      log_tid.delete(); log_cyc.delete();
      drain(100, "t2_timeout");
      chk("t2_nbeats", log_tid.size(), 12);
      for (int j = 0; j < log_tid.size(); j++) begin
         chk("t2_tid", log_tid[j], j % N);
         if (j > 0) chk("t2_gap", log_cyc[j] - log_cyc[j-1], 2);
      end

      // src1 three-beat packet, sink stalls 5 cycles on beat 2 while src2 waits
      load_pkt(1, 3);
      log_tid.delete(); log_cyc.delete();
      base = acc_cnt[1];
      wait_acc(1, base + 1, 50, "t3_first_beat");
      m_rdy = 1'b0;
      load_pkt(2, 1);
      stall_d = exp_q[1][0].d;
      for (int j = 0; j < 5; j++) begin
         step();
         chk("t3_grant", grant, 4'b0010);
         chk("t3_sready1", s_axis_tready[1], 0);
         chk("t3_data_hold", m_axis_tdata, stall_d);
         chk("t3_mvalid", m_axis_tvalid, 1);
      end
      m_rdy = 1'b1;
      drain(50, "t3_timeout");
      chk("t3_nbeats", log_tid.size(), 4);
      if (log_tid.size() == 4) begin
         chk("t3_tid1", log_tid[2], 1);
         chk("t3_tid_next", log_tid[3], 2);
      end

      // src3 drops valid mid-packet; grant stays locked while src0 waits
      load_pkt(3, 4);
      load_pkt(0, 1);
      log_tid.delete(); log_cyc.delete();
      base = acc_cnt[3];
      wait_acc(3, base + 2, 50, "t4_two_beats");
      drop[3] = 1'b1;
      for (int j = 0; j < 2; j++) begin
         step();
         chk("t4_grant", grant, 4'b1000);
         chk("t4_bubble", m_axis_tvalid, 0);
      end
      drop[3] = 1'b0;
      drain(50, "t4_timeout");
      chk("t4_nbeats", log_tid.size(), 5);
      if (log_tid.size() == 5) begin
         chk("t4_tid3", log_tid[3], 3);
         chk("t4_tid0", log_tid[4], 0);
      end

      // Reset during beat 2 of a src2 packet; priority restarts at src0
      load_pkt(2, 4);
      base = acc_cnt[2];
      wait_acc(2, base + 1, 50, "t5_first_beat");
      rst_req = 1'b1;
      step();
      rst_req = 1'b0;
      flush_all();
      step();
      chk("t5_grant", grant, 0);
      chk("t5_mvalid", m_axis_tvalid, 0);
      chk("t5_busy", busy, 0);
      chk("t5_tid", m_axis_tid, 0);
      load_pkt(1, 1);
      load_pkt(2, 1);
      log_tid.delete(); log_cyc.delete();
      drain(50, "t5_timeout");
      chk("t5_nbeats", log_tid.size(), 2);
      if (log_tid.size() == 2) begin
         chk("t5_first", log_tid[0], 1);
         chk("t5_second", log_tid[1], 2);
      end

      // Random traffic scoreboard
      vld_pct = 80;
      rdy_pct = 80;
      target = beats_out + 10000;
      k = 0;
      while (beats_out < target && k < 60000) begin
         for (int s = 0; s < N; s++)
            if (src_q[s].size() < 4) load_pkt(s, int'($urandom_range(1, 8)));
         step();
         k++;
      end
      chk("t6_timeout", beats_out >= target, 1);
      vld_pct = 100;
      rdy_pct = 100;
      drain(2000, "t6_drain");
      for (int s = 0; s < N; s++)
         chk("t6_exp_empty", exp_q[s].size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
